// File: rtl/xh_rom_arb.sv
// Round-robin two-client read arbiter/sequencer for the display-path xh_rom.
// Optional last-row hit bypass is enabled by defining XH_ROM_HIT_BYPASS_EN.
module xh_rom_arb #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 224
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
`ifdef XH_ROM_HIT_BYPASS_EN
    localparam logic [1:0] S_HIT   = 2'd3;
`endif

    logic [1:0]        state, state_d;
    logic              ptr, ptr_d;
    logic              cur_id, cur_id_d;
    logic              gnt0_d, gnt1_d;
    logic              rsp_valid_d, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_d;
    logic [ADDR_W-1:0] rom_addr_d;
    logic              busy_d;
    logic              win_id_c;
    logic [ADDR_W-1:0] win_addr_c;
`ifdef XH_ROM_HIT_BYPASS_EN
    logic [ADDR_W-1:0] last_addr, last_addr_d;
    logic              last_valid, last_valid_d;
`endif

    // On a tie the requester that did not win last time is chosen.
    assign win_id_c   = (req0 && req1) ? ~ptr : req1;
    assign win_addr_c = win_id_c ? addr1 : addr0;

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        cur_id_d    = cur_id;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id;
        rsp_data_d  = rsp_data;
        rom_addr_d  = rom_addr;
`ifdef XH_ROM_HIT_BYPASS_EN
        last_addr_d  = last_addr;
        last_valid_d = last_valid;
`endif
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt0_d   = ~win_id_c;
                    gnt1_d   = win_id_c;
                    ptr_d    = win_id_c;
                    cur_id_d = win_id_c;
`ifdef XH_ROM_HIT_BYPASS_EN
                    // Repeat of the last fetched row: answer from rsp_data directly.
                    if (last_valid && (win_addr_c == last_addr)) begin
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = win_id_c;
                        state_d     = S_HIT;
                    end else begin
                        rom_addr_d = win_addr_c;
                        state_d    = S_ISSUE;
                    end
`else
                    rom_addr_d = win_addr_c;
                    state_d    = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                rsp_data_d  = rom_data;
                rsp_id_d    = cur_id;
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
`ifdef XH_ROM_HIT_BYPASS_EN
                last_addr_d  = rom_addr;
                last_valid_d = 1'b1;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= 1'b1;
            cur_id    <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rom_addr  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            cur_id    <= cur_id_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_data  <= rsp_data_d;
            rom_addr  <= rom_addr_d;
            busy      <= busy_d;
        end
    end

`ifdef XH_ROM_HIT_BYPASS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr  <= '0;
            last_valid <= 1'b0;
        end else begin
            last_addr  <= last_addr_d;
            last_valid <= last_valid_d;
        end
    end
`endif

endmodule
